// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Stalls the pipeline while a miss writes back the victim line and refills from memory.
module dcache_ctrl #(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          data_i,
    input  logic                 MemRead_i,
    input  logic                 MemWrite_i,
    output logic [31:0]          data_o,
    output logic                 stall_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int OFF_W  = $clog2(LINE_BITS / 8);
    localparam int WORD_W = $clog2(LINE_BITS / 32);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;

    state_t state, state_next;

    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_BITS-1:0] data_mem [NUM_LINES];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] word;
    logic              req;
    logic              hit;
    logic              wr_hit;
    logic              fill;
    logic              unused_addr_bits;

    assign idx              = addr_i[OFF_W +: IDX_W];
    assign tag              = addr_i[31 -: TAG_W];
    assign word             = addr_i[2 +: WORD_W];
    assign unused_addr_bits = ^addr_i[1:0];

    assign req    = MemRead_i | MemWrite_i;
    assign hit    = valid[idx] && (tag_mem[idx] == tag);
    assign wr_hit = (state == IDLE) && MemWrite_i && hit;
    assign fill   = (state == ALLOCATE) && mem_ack_i;

    // Gated by rst_i so the pipeline is released the instant reset is asserted.
    assign stall_o = rst_i && ((state != IDLE) || (req && !hit));
    assign data_o  = (rst_i && (state == IDLE) && req && hit)
                   ? data_mem[idx][{word, 5'b0} +: 32] : 32'h0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'h0;
        mem_data_o   = '0;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    state_next = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_mem[idx], idx, {OFF_W{1'b0}}};
                mem_data_o   = data_mem[idx];
                if (mem_ack_i) state_next = ALLOCATE;
            end
            ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag, idx, {OFF_W{1'b0}}};
                if (mem_ack_i) state_next = REFILL;
            end
            REFILL: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (wr_hit) begin
            dirty[idx] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays are not reset; the cleared valid bits make their contents irrelevant.
    always_ff @(posedge clk_i) begin
        if (fill) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= mem_data_i;
        end else if (wr_hit) begin
            data_mem[idx][{word, 5'b0} +: 32] <= data_i;
        end
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the MEM stage and the data memory.
- Produces the memory stall signal that freezes the pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC while a miss is serviced.
- Talks to the 256-bit-line data memory through an enable/ack handshake.

Parameters:
- NUM_LINES, 32, number of cache lines; index width = log2(NUM_LINES).
- LINE_BITS, 256, line size in bits (32 bytes, 8 words).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- addr_i  in  32  CPU byte address (word aligned)
- data_i  in  32  CPU store data
- MemRead_i  in  1  load request
- MemWrite_i  in  1  store request
- data_o  out  32  load data, valid when stall_o=0
- stall_o  out  1  memory stall to pipeline and PC
- mem_addr_o  out  32  line address to memory, low 5 bits zero
- mem_data_o  out  256  writeback line data
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1=write line, 0=read line
- mem_data_i  in  256  refill line data
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Address split:
  - offset = addr_i[4:0]; word select = addr_i[4:2].
  - index = addr_i[9:5].
  - tag = addr_i[31:10], 22 bits.
- Storage per line: valid, dirty, tag[21:0], data[255:0].
- Reset (async, rst_i=0):
  - All valid and dirty bits cleared; state=IDLE.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - stall_o=0, data_o=0.
  - Reset mid-miss aborts the transaction and returns to IDLE; the memory sees mem_enable_o drop asynchronously.
- Request:
  - req = MemRead_i | MemWrite_i. If both are asserted, treat as a write.
  - hit = valid[index] & (tag_store[index]==tag).
- stall_o is combinational: 1 when (state==IDLE & req & ~hit) or state!=IDLE.
- data_o is combinational: the selected word of line[index] when req & hit & state==IDLE, otherwise 0.
- Write hit:
  - On the clock edge, the selected word is replaced by data_i and dirty[index] is set.
  - Zero stall.
- FSM states: IDLE, WRITEBACK, ALLOCATE, REFILL.
  - IDLE → WRITEBACK when req & ~hit & valid & dirty.
  - IDLE → ALLOCATE when req & ~hit & ~(valid & dirty).
  - IDLE otherwise stays in IDLE.
  - WRITEBACK:
    - mem_enable_o=1, mem_write_o=1.
    - mem_addr_o = {old_tag, index, 5'b0}; mem_data_o = line[index].
    - → ALLOCATE on mem_ack_i.
  - ALLOCATE:
    - mem_enable_o=1, mem_write_o=0, mem_addr_o = {tag, index, 5'b0}.
    - On mem_ack_i: latch mem_data_i into line[index], tag_store=tag, valid=1, dirty=0; → REFILL.
  - REFILL:
    - One bubble cycle, stall_o=1.
    - → IDLE, where the access now hits and is completed as a normal hit (a store sets dirty then).
- mem_enable_o and mem_write_o are decoded from state, so the request drops the cycle after the ack edge.
- mem_ack_i outside WRITEBACK or ALLOCATE is ignored.
- addr_i, data_i, MemRead_i and MemWrite_i are held stable by the stalled pipeline during a miss. The controller uses the live inputs; they are not latched.
- No request (req=0): no state change, stall_o=0.
- Miss latency:
  - Clean miss: 1 (detect) + N_ack (ALLOCATE) + 1 (REFILL) stall cycles.
  - Dirty miss: adds the WRITEBACK wait.
- Memory latency is unbounded; the controller waits indefinitely for the ack.

Test Plan:
- Reset, then load 0x0000_0400 (index 0, tag 1) with memory ack after 10 cycles and line word0=0xDEAD_BEEF → stall_o high through ALLOCATE and REFILL, one ALLOCATE read at mem_addr_o=0x400, then data_o=0xDEAD_BEEF with stall_o=0.
- Store 0x1234_5678 to 0x0000_0404 after the above → no stall; a following load of 0x404 returns 0x1234_5678 with zero stall.
- Load 0x0000_0800 (same index, tag 2) with line 0 dirty → WRITEBACK at mem_addr_o=0x400, mem_write_o=1, mem_data_o word1=0x1234_5678; then ALLOCATE at 0x800; stall_o released only after REFILL.
- MemRead_i=MemWrite_i=0 with a random addr_i for 20 cycles → stall_o=0, no mem_enable_o, no state change.
- Spurious mem_ack_i pulses while IDLE → ignored, with no tag or valid change.
- Assert rst_i=0 during an ALLOCATE wait → mem_enable_o=0 and stall_o=0 immediately. After release, the previously targeted line is invalid and the next load of it misses.
